uart_rx_fifo: RTL and testbench

- Receive buffer that sits directly downstream of the UART receiver, on the same 50 MHz clock.
- Captures each completed frame, signalled by a rising edge of the receiver's level-type rx_ready flag, into a DEPTH-entry FIFO.
- Presents the frames to the consumer over a valid/ready handshake.
- Reports fill level, full/empty status and a sticky overflow flag, so frame bursts at 115200 baud are not lost while the consumer is busy.

---
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: captures one frame per rx_ready rising edge.
// Optional UART_RX_FIFO_ERR_DROP_EN: errored frames are dropped and counted in err_cnt.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk50m,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_ready,
  input  logic                   rx_error,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_err,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   ovf_clr
`ifdef UART_RX_FIFO_ERR_DROP_EN
  ,output logic [7:0]            err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
`ifdef UART_RX_FIFO_ERR_DROP_EN
  localparam int EW = WIDTH;
`else
  localparam int EW = WIDTH + 1;
`endif
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_rdy_q;
  logic          r_overflow;
  logic [AW:0]   w_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push_req;
  logic          w_pop;
  logic          w_err_drop;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == FULL_LVL);
  assign w_empty = (w_level == PTR_ZERO);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Push/pop decisions; a pop in the same cycle frees the slot a full FIFO needs.
  always_comb begin
    w_push_req = rx_ready & ~r_rdy_q;
    w_pop      = ~w_empty & out_ready;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    w_err_drop = w_push_req & rx_error;
    w_entry    = rx_data;
`else
    w_err_drop = 1'b0;
    w_entry    = {rx_error, rx_data};
`endif
    w_push_ok  = w_push_req & ~w_err_drop & (~w_full | w_pop);
    w_ovf_set  = w_push_req & ~w_err_drop & w_full & ~w_pop;
  end

  // Storage array; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk50m) begin
    if (w_push_ok && !rst) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end
  end

  // Pointers, edge register and sticky overflow; rdy_q resets high to ignore a stale ready.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_wr_ptr   <= PTR_ZERO;
      r_rd_ptr   <= PTR_ZERO;
      r_rdy_q    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_rdy_q <= rx_ready;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic [7:0] r_err_cnt;

  // Saturating count of dropped errored frames.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_drop && (r_err_cnt != 8'd255)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt  = r_err_cnt;
  assign out_data = w_head;
  assign out_err  = 1'b0;
`else
  assign out_data = w_head[WIDTH-1:0];
  assign out_err  = w_head[WIDTH];
`endif

  assign out_valid = ~w_empty;
  assign level     = w_level;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue model compared every cycle plus directed literal checks.
module tb_uart_rx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk50m = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;
  logic             rx_error;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       level;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             ovf_clr;
`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic [7:0]       err_cnt;
`endif

  always #10 clk50m = ~clk50m;

  uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk50m(clk50m), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_error(rx_error), .out_data(out_data), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .full(full),
    .empty(empty), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef UART_RX_FIFO_ERR_DROP_EN
    , .err_cnt(err_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {err,data}, a sticky flag and an error counter.
  logic [WIDTH:0] m_q[$];
  bit             m_ovf    = 1'b0;
  bit             m_rdy_q  = 1'b1;
  int             m_errcnt = 0;
  bit             m_live   = 1'b0;

  always @(posedge clk50m) begin
    bit preq, pop, room, set_ovf;
    if (rst) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_rdy_q  = 1'b1;
      m_errcnt = 0;
    end else begin
      preq    = rx_ready && !m_rdy_q;
      pop     = (m_q.size() > 0) && out_ready;
      room    = (m_q.size() < DEPTH) || pop;
      set_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (preq && DROP && rx_error) begin
        if (m_errcnt < 255) m_errcnt++;
      end else if (preq) begin
        if (room) m_q.push_back({rx_error, rx_data});
        else set_ovf = 1'b1;
      end
      if (set_ovf) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_rdy_q = rx_ready;
    end
    m_live = 1'b1;
  end

  always @(negedge clk50m) begin
    if (m_live) begin
      check("m_level", 32'(level), 32'(m_q.size()));
      check("m_full", 32'(full), 32'(m_q.size() == DEPTH));
      check("m_empty", 32'(empty), 32'(m_q.size() == 0));
      check("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
      if (m_q.size() > 0) begin
        check("m_out_data", 32'(out_data), 32'(m_q[0][WIDTH-1:0]));
        check("m_out_err", 32'(out_err), 32'(m_q[0][WIDTH]));
      end
`ifdef UART_RX_FIFO_ERR_DROP_EN
      check("m_err_cnt", 32'(err_cnt), 32'(m_errcnt));
`endif
    end
  end

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e);
    rx_data  = d;
    rx_error = e;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    rx_error = 1'b0;
    tick();
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < DEPTH; i++) send_frame(8'(base + i), 1'b0);
  endtask

  task automatic drain_check(input string name, input logic [7:0] base, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(name, 32'(out_data), 32'(8'(base + i)));
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_ready = 1'b0; rx_data = 8'h00; rx_error = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    // Single frame with one-cycle latency, then a long-held ready must not re-push.
    rx_data = 8'h5A; rx_error = 1'b0; rx_ready = 1'b1;
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h5A);
    check("single_level", 32'(level), 32'd1);
    repeat (100) tick();
    check("hold_level", 32'(level), 32'd1);
    rx_ready = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_drained", 32'(empty), 32'd1);

    // Burst fill and in-order drain with pointer wrap.
    fill(8'h00);
    check("burst_full", 32'(full), 32'd1);
    check("burst_level", 32'(level), 32'd16);
    drain_check("burst_drain", 8'h00, 16);
    check("burst_empty", 32'(empty), 32'd1);
    check("burst_valid", 32'(out_valid), 32'd0);

    // Overflow drops the extra frame; ovf_clr clears the sticky flag.
    fill(8'h10);
    send_frame(8'hAA, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_level", 32'(level), 32'd16);
    drain_check("ovf_drain", 8'h10, 16);
    check("ovf_drain_empty", 32'(empty), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Push and pop in the same cycle while full.
    fill(8'h20);
    rx_data = 8'hBB; rx_ready = 1'b1; out_ready = 1'b1;
    tick();
    rx_ready = 1'b0; out_ready = 1'b0;
    check("simul_ovf", 32'(overflow), 32'd0);
    check("simul_level", 32'(level), 32'd16);
    drain_check("simul_drain", 8'h21, 15);
    check("simul_last", 32'(out_data), 32'hBB);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("simul_empty", 32'(empty), 32'd1);

    // Errored frame.
    rx_data = 8'h33; rx_error = 1'b1; rx_ready = 1'b1;
    tick();
`ifdef UART_RX_FIFO_ERR_DROP_EN
    check("err_cnt", 32'(err_cnt), 32'd1);
    check("err_empty", 32'(empty), 32'd1);
`else
    check("err_data", 32'(out_data), 32'h33);
    check("err_tag", 32'(out_err), 32'd1);
`endif
    rx_ready = 1'b0; rx_error = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-operation with level 5, overflow set and a frame edge in the reset cycle.
    fill(8'h40);
    send_frame(8'hCC, 1'b0);
    out_ready = 1'b1;
    repeat (11) tick();
    out_ready = 1'b0;
    check("pre_rst_level", 32'(level), 32'd5);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    rx_data = 8'hDD; rx_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    repeat (3) tick();
    check("post_rst_nopush", 32'(level), 32'd0);
    rx_ready = 1'b0;
    tick();

    // Mixed traffic against the model.
    repeat (400) begin
      rx_data   = 8'($urandom);
      rx_error  = ($urandom_range(0, 7) == 0);
      rx_ready  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) == 0);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      tick();
    end
    rx_ready = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
